// File: rtl/vcdl_pkg.sv
// Shared types and defaults for the VCDL loop controller.
package vcdl_pkg;

    localparam int CODE_W_DEF   = 6;
    localparam int FILT_TH_DEF  = 8;
    localparam int LOCK_CNT_DEF = 16;

    // Threshold range is 1..15, so the accumulator must hold +/-15
    localparam int THR_W = 4;
    localparam int ACC_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } vcdl_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } vcdl_dir_e;

endpackage

// File: rtl/vcdl_step_filter.sv
// Signed phase-detector accumulator; emits a single-cycle step pulse when +/-thr is reached.
module vcdl_step_filter
    import vcdl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample,
    input  logic             early,
    input  logic [THR_W-1:0] thr,
    output logic             step_up,
    output logic             step_dn
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_inc;
    logic signed [ACC_W-1:0] thr_s;

    always_comb begin
        thr_s   = $signed({1'b0, thr});
        acc_inc = acc_q + (early ? ACC_W'(1) : {ACC_W{1'b1}});
        step_up = sample && (acc_inc >= thr_s);
        step_dn = sample && (acc_inc <= -thr_s);

        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (sample) begin
            acc_d = (step_up || step_dn) ? '0 : acc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/vcdl_loop_ctrl.sv
// Delay-line loop controller: acquisition, filtered tracking and lock detection around a
// saturating control code.
module vcdl_loop_ctrl
    import vcdl_pkg::*;
#(
    parameter int CODE_W   = CODE_W_DEF,
    parameter int FILT_TH  = FILT_TH_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pd_valid,
    input  logic              pd_early,
    input  logic [CODE_W-1:0] code_init,
    output logic [CODE_W-1:0] code,
    output logic              code_upd,
    output logic              locked,
    output logic              sat,
    output logic [1:0]        state
);

    localparam int QW = $clog2(LOCK_CNT + 1);
    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

    vcdl_state_e       state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              upd_q, upd_d;
    logic              locked_q, locked_d;
    logic              sat_q, sat_d;
    vcdl_dir_e         dir_q, dir_d;
    logic [1:0]        rev_q, rev_d;
    logic [QW-1:0]     quiet_q, quiet_d;

    logic             active;
    logic             filt_sample;
    logic [THR_W-1:0] thr;
    logic             step_up;
    logic             step_dn;
    vcdl_dir_e        step_dir;
    logic             at_rail;

    assign active      = en && (state_q != ST_IDLE);
    assign filt_sample = pd_valid && active;
    assign thr         = (state_q == ST_ACQ) ? THR_W'(1) : THR_W'(FILT_TH);

    vcdl_step_filter u_filter (
        .clk     (clk),
        .rst     (rst),
        .clr     (!active),
        .sample  (filt_sample),
        .early   (pd_early),
        .thr     (thr),
        .step_up (step_up),
        .step_dn (step_dn)
    );

    always_comb begin
        if (step_up) begin
            step_dir = DIR_UP;
        end else if (step_dn) begin
            step_dir = DIR_DN;
        end else begin
            step_dir = DIR_NONE;
        end
        at_rail = (step_up && (code_q == CODE_MAX)) || (step_dn && (code_q == '0));
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        upd_d    = 1'b0;
        locked_d = locked_q;
        sat_d    = sat_q;
        dir_d    = dir_q;
        rev_d    = rev_q;
        quiet_d  = quiet_q;

        if (!en) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
            sat_d    = 1'b0;
            dir_d    = DIR_NONE;
            rev_d    = '0;
            quiet_d  = '0;
        end else if (state_q == ST_IDLE) begin
            state_d  = ST_ACQ;
            code_d   = code_init;
            locked_d = 1'b0;
            sat_d    = 1'b0;
            dir_d    = DIR_NONE;
            rev_d    = '0;
            quiet_d  = '0;
        end else if (step_dir != DIR_NONE) begin
            if (at_rail) begin
                sat_d = 1'b1;
            end else begin
                code_d = step_up ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
                upd_d  = 1'b1;
                sat_d  = 1'b0;
            end
            // Rail-clipped requests still count as steps for reversal/unlock history
            dir_d = step_dir;
            case (state_q)
                ST_ACQ: begin
                    if ((dir_q != DIR_NONE) && (dir_q != step_dir)) begin
                        if (rev_q == 2'd1) begin
                            state_d = ST_TRACK;
                            rev_d   = '0;
                            quiet_d = '0;
                        end else begin
                            rev_d = rev_q + 2'd1;
                        end
                    end
                end
                ST_TRACK: begin
                    quiet_d = '0;
                end
                ST_LOCKED: begin
                    if (dir_q == step_dir) begin
                        state_d  = ST_TRACK;
                        locked_d = 1'b0;
                        quiet_d  = '0;
                    end
                end
                default: ;
            endcase
        end else if (filt_sample && (state_q == ST_TRACK)) begin
            if (quiet_q == QW'(LOCK_CNT - 1)) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
                quiet_d  = '0;
                // Unlock needs two same-direction steps taken while locked
                dir_d    = DIR_NONE;
            end else begin
                quiet_d = quiet_q + QW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            upd_q    <= 1'b0;
            locked_q <= 1'b0;
            sat_q    <= 1'b0;
            dir_q    <= DIR_NONE;
            rev_q    <= '0;
            quiet_q  <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            upd_q    <= upd_d;
            locked_q <= locked_d;
            sat_q    <= sat_d;
            dir_q    <= dir_d;
            rev_q    <= rev_d;
            quiet_q  <= quiet_d;
        end
    end

    assign code     = code_q;
    assign code_upd = upd_q;
    assign locked   = locked_q;
    assign sat      = sat_q;
    assign state    = state_q;

endmodule

// File: doc/vcdl_loop_ctrl.md
VCDL_LOOP_CTRL -- requirements
Module: vcdl_loop_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 6, meaning the width of the delay-line control code.
REQ-002 SHALL have parameter FILT_TH, default 8, meaning the TRACK/LOCKED accumulator threshold (range 2..15).
REQ-003 SHALL have parameter LOCK_CNT, default 16, meaning the number of consecutive step-free pd_valid samples needed to declare lock.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: en  in  1  loop enable.
REQ-007 SHALL have ports: pd_valid  in  1  one-cycle phase-detector sample strobe.
REQ-008 SHALL have ports: pd_early  in  1  sample value (1 = delayed edge early, request more delay; 0 = late, request less).
REQ-009 SHALL have ports: code_init  in  CODE_W  code loaded on entry to ACQ.
REQ-010 SHALL have ports: code  out  CODE_W  registered delay-line control code.
REQ-011 SHALL have ports: code_upd  out  1  one-cycle pulse when code changes.
REQ-012 SHALL have ports: locked  out  1  registered lock indicator.
REQ-013 SHALL have ports: sat  out  1  step requested beyond a code rail.
REQ-014 SHALL have ports: state  out  2  current FSM state (IDLE=0, ACQ=1, TRACK=2, LOCKED=3).

Function
REQ-015 SHALL implement the FSM states IDLE, ACQ, TRACK and LOCKED.
REQ-016 IDLE SHALL go to ACQ when en=1; on that edge code<=code_init, acc<=0, all counters<=0, and code_upd stays 0.
REQ-017 Any state SHALL go to IDLE when en=0; code SHALL hold its value; locked, sat and code_upd SHALL be 0; en=0 SHALL take priority over a simultaneous pd_valid.
REQ-018 pd_valid SHALL be ignored in IDLE.
REQ-019 Accumulator SHALL be signed, width enough for +/-FILT_TH; each pd_valid adds +1 if pd_early=1, else -1.
REQ-020 Effective threshold SHALL be 1 in ACQ (every sample steps) and FILT_TH in TRACK/LOCKED.
REQ-021 When acc reaches +threshold: code+1, acc<=0; when acc reaches -threshold: code-1, acc<=0.
REQ-022 Step latency: pd_valid in cycle N SHALL give updated code and code_upd=1 in cycle N+1, with no extra pipeline stage.
REQ-023 Saturation: code SHALL never wrap; a step up at 2^CODE_W-1 or down at 0 SHALL leave code unchanged, set sat=1 and keep code_upd=0.
REQ-024 sat SHALL clear on the next in-range step, or on IDLE entry.
REQ-025 ACQ SHALL go to TRACK after 2 direction reversals, where a reversal is a step opposite to the previous step (saturated requests count as steps).
REQ-026 In TRACK, a quiet counter SHALL increment per pd_valid without a step and clear on any step; reaching LOCK_CNT SHALL go to LOCKED with locked=1 in the same cycle as the state change.
REQ-027 LOCKED SHALL keep stepping code normally; two consecutive steps in the same direction SHALL go to TRACK with locked=0 the next cycle and the quiet counter cleared.
REQ-028 A threshold hit and a state transition on the same sample SHALL both take effect; the new threshold SHALL apply from the next sample.

Reset
REQ-029 When rst=1 at a clk edge: code=0, code_upd=0, locked=0, sat=0, state=IDLE, acc=0, and all counters 0.
REQ-030 Reset mid-operation SHALL abandon any pending accumulation; the next en=1 SHALL restart from code_init.
REQ-031 No output SHALL depend combinationally on rst.

Structure
REQ-032 Shared package vcdl_pkg SHALL hold the state enum (2-bit encoding above), default CODE_W, FILT_TH and LOCK_CNT constants, and the step direction type.
REQ-033 Sub-module vcdl_step_filter SHALL contain the accumulator and threshold compare; inputs are the sample and the threshold, and outputs are step_up and step_dn pulses.
REQ-034 The FSM, code register and counters SHALL stay in vcdl_loop_ctrl.

Verification
REQ-035 Reset/enable: rst, then en=1 with code_init=20 -> cycle after, code=20, state=ACQ, code_upd=0.
REQ-036 Acquisition: code_init=20, 5 samples early, then alternating late/early -> code 21..25, reversal to 24, 25, then state=TRACK; code_upd pulses each step, one cycle after each pd_valid.
REQ-037 Filter/lock: in TRACK, 7 early then 1 late -> no step; 8 consecutive early -> one step (+1); then 16 alternating samples -> locked=1, state=LOCKED.
REQ-038 Unlock: in LOCKED, 16 early samples (2 up steps) -> state=TRACK, locked=0.
REQ-039 Saturation: code_init=62, 3 early samples in ACQ -> code=63, then sat=1 with code 63 and no code_upd; a later late step -> code=62, sat=0.
REQ-040 Priority/reset mid-run: en=0 with pd_valid=1 in the same cycle -> state=IDLE, code unchanged; rst during LOCKED -> all outputs at reset values the next cycle.
